// File: rtl/bpu_pkg.sv
// Shared branch-predictor types: branch kinds, BTB entry layout and default sizes.
package bpu_pkg;

  typedef logic [31:0] word_t;

  localparam int BTB_ENTRIES_DEFAULT = 32;
  localparam int RAS_DEPTH_DEFAULT   = 8;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_e;

  // Tag is held at full word width; only the bits above the index are ever non-zero.
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    br_type_e   btype;
    logic [1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry when full.
module ras
  import bpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t push_data,
  output word_t top,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);

  word_t         stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_m1;
  logic [PW:0]   count;
  logic          replace;

  assign ptr_m1  = ptr - PW'(1);
  assign empty   = (count == '0);
  assign top     = stack[ptr_m1];
  assign replace = push & pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (replace) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_m1;
      count <= count - (PW+1)'(1);
    end
  end

  // Simultaneous call/return rewrites the current top in place.
  always_ff @(posedge clk) begin
    if (push) begin
      if (replace) stack[ptr_m1] <= push_data;
      else         stack[ptr]    <= push_data;
    end
  end

endmodule

// File: rtl/bpu.sv
// Direct-mapped BTB branch predictor with 2-bit counters; return stack enabled by BPU_RAS_EN.
module bpu
  import bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter int RAS_DEPTH   = RAS_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pre_pc,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic [1:0]  u_type,
  input  logic        u_is_call,
  input  logic        u_is_ret
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  btb_entry_t       btb [BTB_ENTRIES];
  logic [IDX_W-1:0] f_idx, u_idx;
  word_t            f_tag, u_tag;
  btb_entry_t       f_ent, u_ent;
  logic             f_hit, u_hit, btb_taken;

  assign f_idx = f_pc[IDX_W+1:2];
  assign u_idx = u_pc[IDX_W+1:2];
  assign f_tag = f_pc >> (IDX_W + 2);
  assign u_tag = u_pc >> (IDX_W + 2);
  assign f_ent = btb[f_idx];
  assign u_ent = btb[u_idx];

  assign f_hit     = f_valid & f_ent.valid & (f_ent.tag == f_tag);
  assign u_hit     = u_ent.valid & (u_ent.tag == u_tag);
  assign btb_taken = f_hit & ((f_ent.btype != BR) | f_ent.ctr[1]);

`ifdef BPU_RAS_EN
  word_t ras_top;
  logic  ras_empty;

  ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (u_valid & u_is_call),
    .pop       (u_valid & u_is_ret),
    .push_data (u_pc + 32'd8),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_comb begin
    pred_taken = btb_taken;
    pre_pc     = btb_taken ? f_ent.target : 32'h0;
    if (f_hit && f_ent.btype == RET && !ras_empty) begin
      pred_taken = 1'b1;
      pre_pc     = ras_top;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{u_is_call, u_is_ret};

  always_comb begin
    pred_taken = btb_taken;
    pre_pc     = btb_taken ? f_ent.target : 32'h0;
  end
`endif

  // Lookup above reads the pre-edge array, so a same-index update is never bypassed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= 2'b00;
      end
    end else if (u_valid) begin
      if (u_hit) begin
        btb[u_idx].ctr <= u_taken ? ctr_inc(u_ent.ctr) : ctr_dec(u_ent.ctr);
        if (u_taken) begin
          btb[u_idx].target <= u_target;
          btb[u_idx].btype  <= br_type_e'(u_type);
        end
      end else if (u_taken) begin
        btb[u_idx] <= '{valid: 1'b1, tag: u_tag, target: u_target,
                        btype: br_type_e'(u_type), ctr: 2'b10};
      end
    end
  end

endmodule

// File: tb/tb_bpu.sv
// Bench for bpu: directed scenarios plus random traffic against a behavioural predictor model.
module tb_bpu;

  localparam int N = 32;
  localparam int D = 8;
  localparam logic [1:0] T_BR = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

  logic        clk = 1'b0;
  logic        reset, f_valid, pred_taken, u_valid, u_taken, u_is_call, u_is_ret;
  logic [31:0] f_pc, pre_pc, u_pc, u_target;
  logic [1:0]  u_type;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-slot owner PC, plain integer counter, queue for the return stack.
  bit          m_valid [N];
  int unsigned m_owner [N];
  int unsigned m_tgt   [N];
  int          m_ctr   [N];
  int          m_type  [N];
  logic [31:0] ras_q   [$];

  bpu dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .pred_taken(pred_taken), .pre_pc(pre_pc),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_type(u_type), .u_is_call(u_is_call), .u_is_ret(u_is_ret)
  );

  always #5 clk = ~clk;

  function automatic int slot(input int unsigned pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit same_line(input int unsigned a, input int unsigned b);
    return (a / (4 * N)) == (b / (4 * N));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    bit          pt;
    logic [31:0] tgt;
    int          s;
    pt  = 1'b0;
    tgt = 32'h0;
    s   = slot(f_pc);
    if (f_valid && m_valid[s] && same_line(m_owner[s], f_pc)) begin
      pt  = (m_type[s] != T_BR) || (m_ctr[s] >= 2);
      tgt = pt ? m_tgt[s] : 32'h0;
`ifdef BPU_RAS_EN
      if (m_type[s] == T_RET && ras_q.size() > 0) begin
        pt  = 1'b1;
        tgt = ras_q[$];
      end
`endif
    end
    chk({tag, ".model_taken"}, {31'b0, pred_taken}, {31'b0, pt});
    chk({tag, ".model_pc"}, pre_pc, tgt);
  endtask

  task automatic model_update();
    int s;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 0;
      end
      ras_q.delete();
    end else if (u_valid) begin
      s = slot(u_pc);
      if (m_valid[s] && same_line(m_owner[s], u_pc)) begin
        if (u_taken) begin
          if (m_ctr[s] < 3) m_ctr[s]++;
          m_tgt[s]  = u_target;
          m_type[s] = int'(u_type);
        end else if (m_ctr[s] > 0) begin
          m_ctr[s]--;
        end
      end else if (u_taken) begin
        m_valid[s] = 1'b1;
        m_owner[s] = u_pc;
        m_tgt[s]   = u_target;
        m_type[s]  = int'(u_type);
        m_ctr[s]   = 2;
      end
`ifdef BPU_RAS_EN
      if (u_is_call && u_is_ret) begin
        if (ras_q.size() > 0) ras_q[ras_q.size()-1] = u_pc + 32'd8;
        else                  ras_q.push_back(u_pc + 32'd8);
      end else if (u_is_call) begin
        ras_q.push_back(u_pc + 32'd8);
        if (ras_q.size() > D) void'(ras_q.pop_front());
      end else if (u_is_ret && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
`endif
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Settle, compare against the model and against the stated expectation.
  task automatic look(input string tag, input bit ept, input logic [31:0] epc);
    #2;
    model_check(tag);
    chk({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, ept});
    chk({tag, ".pc"}, pre_pc, epc);
  endtask

  task automatic idle_u();
    u_valid = 0; u_taken = 0; u_is_call = 0; u_is_ret = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input logic [1:0] ty, input bit call, input bit ret);
    u_valid = 1; u_pc = pc; u_taken = tk; u_target = tgt; u_type = ty;
    u_is_call = call; u_is_ret = ret;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    case ($urandom % 4)
      0:       base = 32'h0000_0000;
      1:       base = 32'h0000_1000;
      2:       base = 32'h8000_0000;
      default: base = 32'hBFC0_0000;
    endcase
    return base | (32'($urandom % 6) << 2) | (32'($urandom % 2) << 7);
  endfunction

  initial begin
    logic [31:0] call_pc;
    bit          ras_on;
`ifdef BPU_RAS_EN
    ras_on = 1'b1;
`else
    ras_on = 1'b0;
`endif
    reset = 1; f_valid = 0; f_pc = 0; u_pc = 0; u_target = 0; u_type = T_BR;
    idle_u();
    #1;
    edge_step();
    edge_step();
    reset = 0;

    // Reset state
    f_valid = 1; f_pc = 32'hBFC0_0000;
    look("reset_lookup", 0, 32'h0);
    f_pc = 32'h1234_5678;
    look("reset_any_pc", 0, 32'h0);
    edge_step();

    // Allocate a taken branch, then train it down
    f_pc = 32'hBFC0_0000;
    upd(32'hBFC0_0010, 1, 32'hBFC0_0100, T_BR, 0, 0);
    look("alloc_cycle", 0, 32'h0);
    edge_step();
    idle_u();
    f_pc = 32'hBFC0_0010;
    look("br_hit", 1, 32'hBFC0_0100);
    edge_step();
    upd(32'hBFC0_0010, 0, 32'h0, T_BR, 0, 0);
    look("nt1_old", 1, 32'hBFC0_0100);
    edge_step();
    look("nt2_ctr1", 0, 32'h0);
    edge_step();
    idle_u();
    look("br_ctr0", 0, 32'h0);
    edge_step();
    f_valid = 0;
    look("no_fvalid", 0, 32'h0);
    f_valid = 1;
    edge_step();

    // Aliasing on one index
    upd(32'h0000_0010, 1, 32'h0000_0100, T_BR, 0, 0);
    edge_step();
    upd(32'h0000_0090, 1, 32'h0000_0200, T_JMP, 0, 0);
    edge_step();
    idle_u();
    f_pc = 32'h0000_0010;
    look("alias_miss", 0, 32'h0);
    edge_step();
    f_pc = 32'h0000_0090;
    look("alias_hit", 1, 32'h0000_0200);
    edge_step();

    // Same-cycle lookup and allocation at index 4, with no bypass
    reset = 1;
    edge_step();
    reset = 0;
    f_pc = 32'h0000_1010;
    upd(32'h0000_1010, 1, 32'h0000_3000, T_JMP, 0, 0);
    look("nobypass_same", 0, 32'h0);
    edge_step();
    idle_u();
    look("nobypass_next", 1, 32'h0000_3000);
    edge_step();

    // Reset wins over a simultaneous update
    reset = 1;
    upd(32'h0000_2020, 1, 32'h0000_4000, T_JMP, 0, 0);
    edge_step();
    reset = 0;
    idle_u();
    f_pc = 32'h0000_2020;
    look("reset_drops_upd", 0, 32'h0);
    edge_step();

    // Return-address stack scenario
    reset = 1;
    edge_step();
    reset = 0;
    f_pc = 32'h8000_0200;
    upd(32'h8000_0100, 1, 32'h8000_1000, T_CALL, 1, 0);
    edge_step();
    upd(32'h8000_0200, 1, 32'h0000_0000, T_RET, 0, 0);
    edge_step();
    idle_u();
    look("ret_pred", 1, ras_on ? 32'h8000_0108 : 32'h0);
    edge_step();
    for (int k = 1; k <= 9; k++) begin
      upd(32'h8001_0000 + 32'(k * 16), 0, 32'h0, T_CALL, 1, 0);
      #2;
      model_check("ras_call");
      edge_step();
    end
    idle_u();
    look("ras_full_top", 1, ras_on ? 32'h8001_0098 : 32'h0);
    edge_step();
    for (int i = 0; i < 8; i++) begin
      upd(32'h8002_0000, 0, 32'h0, T_BR, 0, 1);
      look("ras_pop", 1, ras_on ? 32'h8001_0008 + 32'((9 - i) * 16) : 32'h0);
      edge_step();
    end
    idle_u();
    look("ras_empty_btb", 1, 32'h0);
    edge_step();
    upd(32'h8002_0000, 0, 32'h0, T_BR, 0, 1);
    look("ras_pop_empty", 1, 32'h0);
    edge_step();
    idle_u();
    look("ras_after_pop9", 1, 32'h0);
    edge_step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom % 100) == 0;
      f_valid   = ($urandom % 8) != 0;
      f_pc      = rand_pc();
      u_valid   = $urandom % 2;
      u_pc      = rand_pc();
      u_taken   = $urandom % 2;
      u_target  = $urandom & 32'hFFFF_FFFC;
      u_type    = 2'($urandom % 4);
      u_is_call = ($urandom % 4) == 0;
      u_is_ret  = ($urandom % 4) == 0;
      #2;
      model_check("rand");
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 The block SHALL run on one clock, with a synchronous, active-high reset.
REQ-002 Parameter BTB_ENTRIES, default 32, SHALL set the number of direct-mapped BTB entries (power of two).
REQ-003 Parameter RAS_DEPTH, default 8, SHALL set the return-address-stack depth (power of two).
REQ-004 Ports SHALL be:
clk  in  1  clock
reset  in  1  sync active-high reset
f_valid  in  1  fetch lookup valid
f_pc  in  32  fetch PC (word_t)
pred_taken  out  1  predicted redirect
pre_pc  out  32  predicted target (word_t)
u_valid  in  1  resolved control transfer from execute
u_pc  in  32  PC of the resolved instruction
u_taken  in  1  actual outcome
u_target  in  32  actual target
u_type  in  2  br_type_e: BR, JMP, CALL, RET
u_is_call  in  1  instruction links (jal/jalr/bal)
u_is_ret  in  1  instruction is jr $ra

Function
REQ-005 Index SHALL be f_pc[log2(BTB_ENTRIES)+1:2]; tag SHALL be f_pc[31:log2(BTB_ENTRIES)+2].
REQ-006 Lookup SHALL be combinational from registered state, with zero-cycle latency.
REQ-007 Hit SHALL be f_valid & entry.valid & tag match.
REQ-008 pred_taken SHALL equal hit & (type!=BR | ctr[1]).
REQ-009 pre_pc SHALL equal the entry target when pred_taken, else 32'h0.
REQ-010 Update SHALL occur at the clk edge when u_valid; u_pc selects index/tag.
REQ-011 On an update hit (tag match), ctr SHALL saturate-increment if u_taken (max 2'b11) and saturate-decrement otherwise (min 2'b00); when u_taken, target SHALL become u_target and type SHALL become u_type.
REQ-012 On an update miss with u_taken, the entry SHALL be allocated/overwritten: valid=1, tag, target=u_target, type=u_type, ctr=2'b10.
REQ-013 On an update miss with !u_taken, the BTB SHALL be left unchanged.
REQ-014 A lookup and update to the same index in the same cycle SHALL return the pre-update (old) entry; there is no bypass.

Reset
REQ-015 When reset is high at an edge, all BTB valid bits SHALL clear, ctrs SHALL clear to 2'b00, and the RAS pointer and count SHALL clear to 0.
REQ-016 After reset, pred_taken SHALL be 0 and pre_pc SHALL be 32'h0 for any f_pc.
REQ-017 Reset SHALL have priority over a simultaneous u_valid; that update is dropped.

Configuration
REQ-018 With BPU_RAS_EN defined:
- u_valid&u_is_call SHALL push u_pc+8 (delay slot).
- u_valid&u_is_ret SHALL pop.
- A hit on a RET entry with RAS count>0 SHALL give pre_pc = RAS top and pred_taken=1.
- A hit on a RET entry with RAS count==0 SHALL use the BTB target.
REQ-019 With BPU_RAS_EN defined, push on full SHALL wrap the pointer and overwrite the oldest entry, with count saturating at RAS_DEPTH.
REQ-020 With BPU_RAS_EN defined, pop on empty SHALL be ignored.
REQ-021 With BPU_RAS_EN defined, simultaneous call and ret SHALL replace the top entry (pop then push), leaving count unchanged; if count was 0 this SHALL behave as a push.
REQ-022 Without BPU_RAS_EN, no RAS SHALL be instantiated, u_is_call/u_is_ret SHALL be ignored, and RET entries SHALL predict their BTB target like JMP.

Structure
REQ-023 br_type_e, btb_entry_t {valid, tag, target, type, ctr}, and defaults BTB_ENTRIES/RAS_DEPTH SHALL live in the shared common package.
REQ-024 The RAS SHALL be sub-module ras (push, pop, push_data, top, empty), instantiated only under BPU_RAS_EN.

Verification
REQ-025 Reset, then f_pc=32'hBFC00000, f_valid=1 -> pred_taken=0, pre_pc=32'h0.
REQ-026 Update u_pc=32'hBFC00010, BR, taken, target 32'hBFC00100; next cycle f_pc=32'hBFC00010 -> pred_taken=1, pre_pc=32'hBFC00100. Two not-taken updates then -> pred_taken=0 (ctr 2->1->0).
REQ-027 Aliasing: allocate 32'h00000010, then a taken update at 32'h00000090 (same index, 32 entries) -> lookup at 32'h00000010 misses, lookup at 32'h00000090 hits.
REQ-028 Same-cycle lookup and first allocating update at index 4 -> that cycle pred_taken=0, next cycle pred_taken=1.
REQ-029 BPU_RAS_EN: call at u_pc=32'h80000100; RET entry at 32'h80000200 (BTB target 32'h0) -> lookup gives pre_pc=32'h80000108. Nine further calls -> count stays 8, eight pops return newest-first, ninth pop ignored, after which lookup gives the BTB target.
REQ-030 Without BPU_RAS_EN: the same RET entry -> pre_pc equals the BTB target, unaffected by calls.
